// File: rtl/fir_pkg.sv
// Shared defaults and FSM state encoding for the FIR stream transmitter and its benches.
package fir_pkg;

   localparam int NB_DEF    = 14;
   localparam int TAPS_DEF  = 9;
   localparam int DEPTH_DEF = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEND   = 2'd1,
      WAIT   = 2'd2,
      FINISH = 2'd3
   } fir_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock sample FIFO with a combinational head word and an occupancy counter.
module sync_fifo #(
   parameter int W     = 14,
   parameter int DEPTH = 16
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   count_q;
   logic          do_push;
   logic          do_pop;

   // Flags come from the pre-edge count, so a push at full is dropped even with a pop.
   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem_q[rd_ptr_q];

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/fir_stream_tx.sv
// Streams FIFO-buffered samples toward the FIR filter input with a programmable
// inter-sample gap, and owns the filter's coefficient registers.
module fir_stream_tx
   import fir_pkg::*;
#(
   parameter int NB    = NB_DEF,
   parameter int TAPS  = TAPS_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          WR_EN,
   input  logic [NB-1:0] WR_DATA,
   output logic          FULL,
   input  logic          COEF_WE,
   input  logic [3:0]    COEF_ADDR,
   input  logic [NB-1:0] COEF_DATA,
   input  logic          START,
   input  logic [15:0]   LEN,
   input  logic [3:0]    GAP,
   output logic          VOUT,
   output logic [NB-1:0] DOUT,
   output logic [NB-1:0] B0,
   output logic [NB-1:0] B1,
   output logic [NB-1:0] B2,
   output logic [NB-1:0] B3,
   output logic [NB-1:0] B4,
   output logic [NB-1:0] B5,
   output logic [NB-1:0] B6,
   output logic [NB-1:0] B7,
   output logic [NB-1:0] B8,
   output logic          BUSY,
   output logic          DONE,
   output fir_state_e    DBG_STATE
);

   // VOUT/DOUT is a one-cycle valid strobe with no ready: the filter takes every
   // sample offered. WR_EN is a push accepted whenever FULL is low.
   fir_state_e    state_q, state_d;
   logic [15:0]   remaining_q, remaining_d;
   logic [3:0]    gap_q, gap_d;
   logic [3:0]    wait_cnt_q, wait_cnt_d;
   logic          vout_q;
   logic [NB-1:0] dout_q;
   logic          done_q;
   logic [NB-1:0] coef_q [16];
   logic          pop;
   logic          fifo_empty;
   logic [NB-1:0] fifo_dout;
   logic          coef_wr;

   sync_fifo #(.W(NB), .DEPTH(DEPTH)) u_fifo (
      .CLK   (CLK),
      .RST   (RST),
      .push  (WR_EN),
      .pop   (pop),
      .din   (WR_DATA),
      .dout  (fifo_dout),
      .full  (FULL),
      .empty (fifo_empty)
   );

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      gap_d       = gap_q;
      wait_cnt_d  = wait_cnt_q;
      pop         = 1'b0;
      case (state_q)
         IDLE: begin
            if (START) begin
               if (LEN != 16'd0) begin
                  remaining_d = LEN;
                  gap_d       = GAP;
                  state_d     = SEND;
               end else begin
                  state_d = FINISH;
               end
            end
         end
         SEND: begin
            if (!fifo_empty) begin
               pop         = 1'b1;
               remaining_d = remaining_q - 1'b1;
               if (remaining_q == 16'd1) begin
                  state_d = FINISH;
               end else if (gap_q != 4'd0) begin
                  wait_cnt_d = gap_q;
                  state_d    = WAIT;
               end
            end
         end
         WAIT: begin
            // The emitted-sample cycle overlaps the first WAIT cycle, so leave on a count of 1.
            if (wait_cnt_q <= 4'd1) state_d = SEND;
            else                    wait_cnt_d = wait_cnt_q - 1'b1;
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign coef_wr = COEF_WE && (state_q == IDLE) && (int'(COEF_ADDR) < TAPS);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= IDLE;
         remaining_q <= '0;
         gap_q       <= '0;
         wait_cnt_q  <= '0;
         vout_q      <= 1'b0;
         dout_q      <= '0;
         done_q      <= 1'b0;
         for (int i = 0; i < 16; i++) coef_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         gap_q       <= gap_d;
         wait_cnt_q  <= wait_cnt_d;
         vout_q      <= pop;
         if (pop)     dout_q <= fifo_dout;
         done_q      <= (state_q == FINISH);
         if (coef_wr) coef_q[COEF_ADDR] <= COEF_DATA;
      end
   end

   assign VOUT      = vout_q;
   assign DOUT      = dout_q;
   assign DONE      = done_q;
   assign BUSY      = (state_q != IDLE);
   assign DBG_STATE = state_q;
   assign B0 = coef_q[0];
   assign B1 = coef_q[1];
   assign B2 = coef_q[2];
   assign B3 = coef_q[3];
   assign B4 = coef_q[4];
   assign B5 = coef_q[5];
   assign B6 = coef_q[6];
   assign B7 = coef_q[7];
   assign B8 = coef_q[8];

endmodule

// File: doc/fir_stream_tx.md
FIR_STREAM_TX -- requirements
Module: fir_stream_tx

Interface
REQ-001 Parameter NB, default 14, sample and coefficient width in bits.
REQ-002 Parameter TAPS, default 9, number of coefficient registers.
REQ-003 Parameter DEPTH, default 16, sample FIFO depth (power of two).
REQ-004 CLK  in  1  single clock; all logic on rising edge.
REQ-005 RST  in  1  reset, synchronous, active-high.
REQ-006 WR_EN  in  1  host push strobe into the sample FIFO.
REQ-007 WR_DATA  in  NB  signed sample to push.
REQ-008 FULL  out  1  FIFO full; a push while high is dropped.
REQ-009 COEF_WE  in  1  coefficient write strobe.
REQ-010 COEF_ADDR  in  4  coefficient index (0..TAPS-1).
REQ-011 COEF_DATA  in  NB  coefficient value.
REQ-012 START  in  1  begin a stream run.
REQ-013 LEN  in  16  number of samples in the run.
REQ-014 GAP  in  4  idle cycles inserted between emitted samples.
REQ-015 VOUT  out  1  DOUT valid strobe toward the filter VIN.
REQ-016 DOUT  out  NB  sample toward the filter DIN.
REQ-017 B0..B8  out  NB each  coefficient registers 0..8, driven to the filter.
REQ-018 BUSY  out  1  run in progress.
REQ-019 DONE  out  1  one-cycle pulse at end of run.

Function
REQ-020 The FSM SHALL have states IDLE, SEND, WAIT, FINISH.
REQ-021 IDLE: START=1 and LEN!=0 SHALL latch LEN into remaining and GAP into gap_reg, then go to SEND; BUSY=1 from the next cycle.
REQ-022 IDLE: START=1 and LEN=0 SHALL go to FINISH without emitting anything.
REQ-023 SEND with FIFO non-empty SHALL pop one word; VOUT=1 and DOUT=word in the following cycle, for exactly one cycle.
REQ-024 SEND with FIFO empty SHALL stall with VOUT=0 and stay in SEND (no error, no timeout).
REQ-025 After a pop: remaining reaches 0 -> FINISH; otherwise gap_reg!=0 -> WAIT; otherwise stay in SEND (back-to-back VOUT).
REQ-026 WAIT SHALL hold VOUT=0 for exactly gap_reg cycles, then return to SEND.
REQ-027 FINISH SHALL assert DONE for one cycle, deassert BUSY, and return to IDLE.
REQ-028 START while BUSY=1 SHALL be ignored; LEN and GAP are sampled only on an accepted START.
REQ-029 DOUT SHALL hold the last emitted sample while VOUT=0.
REQ-030 A push with FULL=1 SHALL be dropped; FULL reflects the pre-edge occupancy, so push and pop together at full drops the push.
REQ-031 A push into an empty FIFO SHALL not be popped in the same cycle; it becomes eligible the next cycle.
REQ-032 FIFO pointers SHALL wrap modulo DEPTH, with occupancy kept as a log2(DEPTH)+1-bit count.
REQ-033 COEF_WE SHALL update Bn only in IDLE with COEF_ADDR<TAPS.
REQ-034 A coefficient write while BUSY, or with COEF_ADDR>=TAPS, SHALL be ignored.
REQ-035 A written coefficient value SHALL appear on its Bn output the next cycle.
REQ-036 FIFO pushes SHALL be accepted in every state.

Reset
REQ-037 RST=1 at an edge SHALL force state IDLE, empty the FIFO, and clear remaining, gap_reg and all Bn.
REQ-038 During and after reset, VOUT, DOUT, BUSY, DONE and FULL SHALL all be 0.
REQ-039 Reset mid-run SHALL drop VOUT at that edge, discard the run, and produce no DONE pulse.

Structure
REQ-040 Package fir_pkg SHALL hold NB, TAPS, DEPTH defaults and the FSM state enum, shared with myfir benches.
REQ-041 The FIFO SHALL be a sub-module named sync_fifo (ports CLK, RST, push, pop, din, dout, full, empty).

Verification
REQ-042 Push 1,2,3; START with LEN=3, GAP=0 -> VOUT high on 3 consecutive cycles with DOUT 1,2,3, then DONE one cycle later.
REQ-043 Push 5 samples; START with LEN=5, GAP=2 -> each VOUT pulse separated by exactly 2 idle cycles, and DONE asserts once.
REQ-044 START with LEN=4 and an empty FIFO, then push one sample every 10 cycles -> 4 VOUT pulses, each one cycle after its push becomes eligible.
REQ-045 Push 17 words with no run active -> FULL=1 after the 16th; the 17th word is never emitted.
REQ-046 Write COEF_ADDR=3, value -7 in IDLE -> B3=-7. The same write while BUSY -> B3 unchanged. A write to COEF_ADDR=12 -> all Bn unchanged.
REQ-047 Assert RST after the 2nd of 5 samples -> VOUT=0 from that edge, FIFO empty, no DONE; START with LEN=0 -> DONE one cycle later and no VOUT.
